// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative shift-add multiply / restoring divide into HI/LO.
// Define MDU_SIGNED_EN for two's-complement operands with sign fix-up on DONE entry.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_mult,
  input  logic             req_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mul_q, mul_d, done_q, done_d, div0_q, div0_d;
  logic [WIDTH-1:0] acc_q, acc_d, wrk_q, wrk_d, opd_q, opd_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] ma, mb, acc_n, wrk_n, fin_hi, fin_lo;
  logic [WIDTH:0] sum, shl, diff;
`ifdef MDU_SIGNED_EN
  logic neg_q, neg_d, rneg_q, rneg_d;
  assign ma = a[WIDTH-1] ? -a : a;
  assign mb = b[WIDTH-1] ? -b : b;
`else
  assign ma = a;
  assign mb = b;
`endif
  // acc holds the product high half / remainder; wrk holds multiplier / quotient
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, wrk_q[0] ? opd_q : '0};
    shl   = {acc_q, wrk_q[WIDTH-1]};
    diff  = shl - {1'b0, opd_q};
    acc_n = mul_q ? sum[WIDTH:1] : (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]);
    wrk_n = mul_q ? {sum[0], wrk_q[WIDTH-1:1]} : {wrk_q[WIDTH-2:0], ~diff[WIDTH]};
`ifdef MDU_SIGNED_EN
    {fin_hi, fin_lo} = mul_q ? (neg_q ? -{acc_n, wrk_n} : {acc_n, wrk_n})
                             : {rneg_q ? -acc_n : acc_n, neg_q ? -wrk_n : wrk_n};
`else
    {fin_hi, fin_lo} = {acc_n, wrk_n};
`endif
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    opd_d   = opd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
`ifdef MDU_SIGNED_EN
    neg_d   = neg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: if (req_mult | req_div) begin
        mul_d   = req_mult;
        div0_d  = 1'b0;
        cnt_d   = '0;
        acc_d   = '0;
        wrk_d   = req_mult ? mb : ma;
        opd_d   = req_mult ? ma : mb;
        state_d = RUN;
`ifdef MDU_SIGNED_EN
        neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
        rneg_d  = a[WIDTH-1];
`endif
        if (!req_mult && b == '0) begin
          state_d = DONE;
          div0_d  = 1'b1;
          done_d  = 1'b1;
          hi_d    = a;
          lo_d    = '1;
        end
      end
      RUN: begin
        acc_d = acc_n;
        wrk_d = wrk_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      acc_q   <= '0;
      wrk_q   <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      opd_q   <= opd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
`ifdef MDU_SIGNED_EN
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end
  assign stall = (state_q == IDLE && (req_mult || req_div)) || state_q == RUN;
  assign busy  = state_q == RUN;
  assign done  = done_q;
  assign div0  = div0_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: random and directed ops checked against an arithmetic reference model.
module tb_mdu_sequencer;
  logic clock, resetn, req_mult, req_div, stall, busy, done, div0;
  logic [31:0] a, b, hi, lo;
  int n_chk = 0, n_err = 0;
  mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .resetn(resetn), .req_mult(req_mult), .req_div(req_div),
    .a(a), .b(b), .stall(stall), .busy(busy), .done(done), .div0(div0),
    .hi(hi), .lo(lo)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_op(input logic m, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!m && y == 0) return {x, 32'hFFFF_FFFF};
`ifdef MDU_SIGNED_EN
    if (m) return 64'(sx * sy);
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
`else
    q = sx; r = sy;
    if (m) return {32'b0, x} * {32'b0, y};
    return {x % y, x / y};
`endif
  endfunction
  task automatic run_op(input logic m, input logic d, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] e;
    logic z;
    int cyc, st, bz;
    z = !m && d && y == 0;
    e = ref_op(m, x, y);
    @(negedge clock);
    req_mult = m; req_div = d; a = x; b = y;
    #1;
    cyc = 0; st = 0; bz = 0;
    while (!done && cyc < 100) begin
      st += int'(stall);
      bz += int'(busy);
      @(negedge clock); #1;
      cyc++;
    end
    req_mult = 0; req_div = 0;
    chk("done_cycle", 64'(cyc), z ? 64'd1 : 64'd33);
    chk("stall_cycles", 64'(st), z ? 64'd1 : 64'd33);
    chk("busy_cycles", 64'(bz), z ? 64'd0 : 64'd32);
    chk("stall_at_done", 64'(stall), 64'd0);
    chk("hi", 64'(hi), 64'(e[63:32]));
    chk("lo", 64'(lo), 64'(e[31:0]));
    chk("div0", 64'(div0), 64'(z));
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      a = $urandom; b = $urandom;
      #1;
      chk("done_pulse", 64'(done), 64'd0);
    end
    chk("hi_stable", 64'(hi), 64'(e[63:32]));
    chk("lo_stable", 64'(lo), 64'(e[31:0]));
  endtask
  initial begin
    resetn = 1; req_mult = 0; req_div = 0; a = 0; b = 0;
    #3 resetn = 0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_hi", 64'(hi), 0);
    chk("rst_lo", 64'(lo), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_div0", 64'(div0), 0);
    chk("rst_stall", 64'(stall), 0);
    resetn = 1;
    run_op(1, 0, 32'd7, 32'd6);
    chk("mult_7x6_lo", 64'(lo), 64'h2A);
    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(0, 1, 32'd100, 32'd7);
    run_op(0, 1, 32'h1234, 32'd0);
    chk("div0_hi", 64'(hi), 64'h1234);
    run_op(1, 0, 32'd3, 32'd9);
    run_op(1, 1, 32'd11, 32'd0);
`ifdef MDU_SIGNED_EN
    run_op(1, 0, -32'sd6, 32'd7);
    chk("smul_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("smul_lo", 64'(lo), 64'hFFFF_FFD6);
    run_op(0, 1, -32'sd7, 32'd2);
    chk("sdiv_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("sdiv_hi", 64'(hi), 64'hFFFF_FFFF);
`endif
    @(negedge clock);
    req_mult = 1; a = 5; b = 5;
    repeat (11) @(negedge clock);
    #1;
    chk("busy_before_rst", 64'(busy), 1);
    resetn = 0; req_mult = 0;
    #1;
    chk("abort_stall", 64'(stall), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_hi", 64'(hi), 0);
    chk("abort_lo", 64'(lo), 0);
    chk("abort_div0", 64'(div0), 0);
    @(negedge clock);
    resetn = 1;
    run_op(1, 0, 32'd5, 32'd5);
    chk("reissue_lo", 64'(lo), 64'd25);
    for (int k = 0; k < 40; k++) begin
      logic m, d;
      logic [31:0] x, y;
      m = 1'($urandom_range(0, 1));
      d = !m || $urandom_range(0, 3) == 0;
      x = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 300);
      case ($urandom_range(0, 4))
        0: y = 0;
        1: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      run_op(m, d, x, y);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
